// File: rtl/param_reg_file.sv
// General-purpose register file: NREG x WIDTH registers, two read ports and one shared
// write bus with clear/load/increment/decrement, wrap or saturate arithmetic and an overflow pulse.
module param_reg_file #(
  parameter int WIDTH    = 8,
  parameter int NREG     = 4,
  parameter int SATURATE = 0,
  parameter int REG_OUT  = 1,
  parameter int BYPASS   = 1,
  localparam int SW      = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SW-1:0]    o1_sel,
  input  logic [SW-1:0]    o2_sel,
  input  logic [1:0]       funsel,
  input  logic [NREG-1:0]  r_en,
  input  logic [WIDTH-1:0] i,
  output logic [WIDTH-1:0] o1,
  output logic [WIDTH-1:0] o2,
  output logic             ovf
);

  localparam logic [1:0] FN_CLEAR = 2'b00;
  localparam logic [1:0] FN_LOAD  = 2'b01;
  localparam logic [1:0] FN_INC   = 2'b10;
  localparam logic [1:0] FN_DEC   = 2'b11;
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  logic [WIDTH-1:0] regs_cur  [NREG];
  logic [WIDTH-1:0] regs_next [NREG];
  logic [NREG-1:0]  ovf_hit;
  logic             ovf_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_reg
      logic [WIDTH-1:0] value_reg;
      logic [WIDTH-1:0] value_next;
      logic             hit;

      // Boundary crossings flag ovf whether the result wraps or saturates.
      always_comb begin
        value_next = value_reg;
        hit        = 1'b0;
        if (r_en[gi]) begin
          case (funsel)
            FN_CLEAR: value_next = '0;
            FN_LOAD:  value_next = i;
            FN_INC: begin
              if (value_reg == ALL_ONES) begin
                hit        = 1'b1;
                value_next = (SATURATE != 0) ? ALL_ONES : '0;
              end else begin
                value_next = value_reg + 1'b1;
              end
            end
            FN_DEC: begin
              if (value_reg == '0) begin
                hit        = 1'b1;
                value_next = (SATURATE != 0) ? '0 : ALL_ONES;
              end else begin
                value_next = value_reg - 1'b1;
              end
            end
            default: value_next = value_reg;
          endcase
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) value_reg <= '0;
        else     value_reg <= value_next;
      end

      assign regs_cur[gi]  = value_reg;
      assign regs_next[gi] = value_next;
      assign ovf_hit[gi]   = hit;
    end
  endgenerate

  // Selects beyond NREG match no entry and therefore read as zero.
  logic [WIDTH-1:0] rd1_cur, rd2_cur, rd1_next, rd2_next;
  always_comb begin
    rd1_cur  = '0;
    rd2_cur  = '0;
    rd1_next = '0;
    rd2_next = '0;
    for (int k = 0; k < NREG; k++) begin
      if (o1_sel == SW'(k)) begin
        rd1_cur  = regs_cur[k];
        rd1_next = regs_next[k];
      end
      if (o2_sel == SW'(k)) begin
        rd2_cur  = regs_cur[k];
        rd2_next = regs_next[k];
      end
    end
  end

  generate
    if (REG_OUT != 0) begin : g_reg_out
      logic [WIDTH-1:0] o1_reg, o2_reg;
      // regs_next equals the held value when not enabled, so it doubles as the bypass source.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          o1_reg <= '0;
          o2_reg <= '0;
        end else begin
          o1_reg <= (BYPASS != 0) ? rd1_next : rd1_cur;
          o2_reg <= (BYPASS != 0) ? rd2_next : rd2_cur;
        end
      end
      assign o1 = o1_reg;
      assign o2 = o2_reg;
    end else begin : g_comb_out
      assign o1 = rd1_cur;
      assign o2 = rd2_cur;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_reg <= 1'b0;
    else     ovf_reg <= |ovf_hit;
  end

  assign ovf = ovf_reg;

endmodule

// File: tb/tb_param_reg_file.sv
// Bench for param_reg_file: four configurations share one stimulus stream and are checked
// against an integer-arithmetic reference model of the register contents.
module tb_param_reg_file;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] o1_sel = '0, o2_sel = '0, funsel = '0;
  logic [3:0] r_en = '0;
  logic [7:0] i = '0;

  logic [7:0] o1_w [4];
  logic [7:0] o2_w [4];
  logic       ovf_w [4];

  int checks = 0;
  int errors = 0;

  // cfg0 default, cfg1 saturating, cfg2 no bypass, cfg3 combinational outputs with NREG=3
  int sat_c [4] = '{0, 1, 0, 0};
  int rout_c[4] = '{1, 1, 1, 0};
  int byp_c [4] = '{1, 1, 0, 1};
  int nreg_c[4] = '{4, 4, 4, 3};

  int         mr [4][4];
  logic [7:0] exp_o1 [4];
  logic [7:0] exp_o2 [4];
  logic       exp_ovf [4];

  always #5 clk = ~clk;

  param_reg_file #(.WIDTH(8), .NREG(4), .SATURATE(0), .REG_OUT(1), .BYPASS(1)) dut0 (
    .clk(clk), .rst(rst), .o1_sel(o1_sel), .o2_sel(o2_sel), .funsel(funsel),
    .r_en(r_en), .i(i), .o1(o1_w[0]), .o2(o2_w[0]), .ovf(ovf_w[0]));
  param_reg_file #(.WIDTH(8), .NREG(4), .SATURATE(1), .REG_OUT(1), .BYPASS(1)) dut1 (
    .clk(clk), .rst(rst), .o1_sel(o1_sel), .o2_sel(o2_sel), .funsel(funsel),
    .r_en(r_en), .i(i), .o1(o1_w[1]), .o2(o2_w[1]), .ovf(ovf_w[1]));
  param_reg_file #(.WIDTH(8), .NREG(4), .SATURATE(0), .REG_OUT(1), .BYPASS(0)) dut2 (
    .clk(clk), .rst(rst), .o1_sel(o1_sel), .o2_sel(o2_sel), .funsel(funsel),
    .r_en(r_en), .i(i), .o1(o1_w[2]), .o2(o2_w[2]), .ovf(ovf_w[2]));
  param_reg_file #(.WIDTH(8), .NREG(3), .SATURATE(0), .REG_OUT(0), .BYPASS(1)) dut3 (
    .clk(clk), .rst(rst), .o1_sel(o1_sel), .o2_sel(o2_sel), .funsel(funsel),
    .r_en(r_en[2:0]), .i(i), .o1(o1_w[3]), .o2(o2_w[3]), .ovf(ovf_w[3]));

  task automatic model_clear();
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++) mr[c][k] = 0;
      exp_o1[c] = 8'h00;
      exp_o2[c] = 8'h00;
      exp_ovf[c] = 1'b0;
    end
  endtask

  // Applies the current inputs to the model as one clock edge.
  task automatic model_edge();
    int old [4];
    int nv;
    int n;
    logic any;
    for (int c = 0; c < 4; c++) begin
      n = nreg_c[c];
      any = 1'b0;
      for (int k = 0; k < 4; k++) old[k] = mr[c][k];
      for (int k = 0; k < n; k++) begin
        if (r_en[k]) begin
          nv = old[k];
          case (funsel)
            2'b00: nv = 0;
            2'b01: nv = int'(i);
            2'b10: if (old[k] == 255) begin any = 1'b1; nv = (sat_c[c] != 0) ? 255 : 0; end
                   else nv = old[k] + 1;
            2'b11: if (old[k] == 0) begin any = 1'b1; nv = (sat_c[c] != 0) ? 0 : 255; end
                   else nv = old[k] - 1;
            default: nv = old[k];
          endcase
          mr[c][k] = nv;
        end
      end
      exp_ovf[c] = any;
      if (int'(o1_sel) >= n) exp_o1[c] = 8'h00;
      else if (rout_c[c] != 0 && byp_c[c] == 0) exp_o1[c] = 8'(old[o1_sel]);
      else exp_o1[c] = 8'(mr[c][o1_sel]);
      if (int'(o2_sel) >= n) exp_o2[c] = 8'h00;
      else if (rout_c[c] != 0 && byp_c[c] == 0) exp_o2[c] = 8'(old[o2_sel]);
      else exp_o2[c] = 8'(mr[c][o2_sel]);
    end
  endtask

  task automatic set_in(input logic [1:0] fs, input logic [3:0] en, input logic [7:0] d,
                        input logic [1:0] s1, input logic [1:0] s2);
    funsel = fs; r_en = en; i = d; o1_sel = s1; o2_sel = s2;
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    $display("[%0t] %s fs=%b en=%b i=%h s1=%0d s2=%0d | cfg0 o1=%h o2=%h ovf=%b",
             $time, tag, funsel, r_en, i, o1_sel, o2_sel, o1_w[0], o2_w[0], ovf_w[0]);
  endtask

  task automatic test_reset();
    set_in(2'b01, 4'b0010, 8'h55, 2'd1, 2'd1);
    cycle("reset_preload");
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (o1_w[c] !== exp_o1[c]) begin
        errors++; $display("FAIL reset_preload cfg%0d o1: got %h expected %h", c, o1_w[c], exp_o1[c]);
      end
    end
    #2 rst = 1'b1;
    #1;
    for (int c = 0; c < 4; c++) begin
      checks += 3;
      if (o1_w[c] !== 8'h00) begin errors++; $display("FAIL reset_async cfg%0d o1: got %h expected 00", c, o1_w[c]); end
      if (o2_w[c] !== 8'h00) begin errors++; $display("FAIL reset_async cfg%0d o2: got %h expected 00", c, o2_w[c]); end
      if (ovf_w[c] !== 1'b0) begin errors++; $display("FAIL reset_async cfg%0d ovf: got %b expected 0", c, ovf_w[c]); end
    end
    set_in(2'b01, 4'b1111, 8'hAA, 2'd1, 2'd2);
    @(posedge clk);
    @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      checks += 2;
      if (o1_w[c] !== 8'h00) begin errors++; $display("FAIL reset_hold cfg%0d o1: got %h expected 00", c, o1_w[c]); end
      if (o2_w[c] !== 8'h00) begin errors++; $display("FAIL reset_hold cfg%0d o2: got %h expected 00", c, o2_w[c]); end
    end
    rst = 1'b0;
    model_clear();
    for (int s = 0; s < 2; s++) begin
      set_in(2'b00, 4'b0000, 8'h00, 2'(s), 2'(s + 2));
      cycle("reset_readback");
      for (int c = 0; c < 4; c++) begin
        checks += 2;
        if (o1_w[c] !== exp_o1[c]) begin errors++; $display("FAIL reset_readback cfg%0d o1: got %h expected %h", c, o1_w[c], exp_o1[c]); end
        if (o2_w[c] !== exp_o2[c]) begin errors++; $display("FAIL reset_readback cfg%0d o2: got %h expected %h", c, o2_w[c], exp_o2[c]); end
      end
    end
  endtask

  // Runs a list of transactions and checks every output of every configuration after each.
  task automatic run_and_check(input string tag, input logic [1:0] fs[], input logic [3:0] en[],
                               input logic [7:0] d[], input logic [1:0] s1[], input logic [1:0] s2[]);
    for (int t = 0; t < fs.size(); t++) begin
      set_in(fs[t], en[t], d[t], s1[t], s2[t]);
      cycle(tag);
      for (int c = 0; c < 4; c++) begin
        checks += 3;
        if (o1_w[c] !== exp_o1[c]) begin errors++; $display("FAIL %s[%0d] cfg%0d o1: got %h expected %h", tag, t, c, o1_w[c], exp_o1[c]); end
        if (o2_w[c] !== exp_o2[c]) begin errors++; $display("FAIL %s[%0d] cfg%0d o2: got %h expected %h", tag, t, c, o2_w[c], exp_o2[c]); end
        if (ovf_w[c] !== exp_ovf[c]) begin errors++; $display("FAIL %s[%0d] cfg%0d ovf: got %b expected %b", tag, t, c, ovf_w[c], exp_ovf[c]); end
      end
    end
  endtask

  task automatic test_bypass_load();
    run_and_check("bypass_load", '{2'b01, 2'b01, 2'b00}, '{4'b1010, 4'b0101, 4'b0000},
                  '{8'h5A, 8'hA5, 8'h00}, '{2'd1, 2'd0, 2'd1}, '{2'd3, 2'd2, 2'd3});
  endtask

  task automatic test_overflow();
    run_and_check("inc_overflow", '{2'b01, 2'b10, 2'b00}, '{4'b0100, 4'b0100, 4'b0000},
                  '{8'hFF, 8'h00, 8'h00}, '{2'd2, 2'd2, 2'd2}, '{2'd2, 2'd2, 2'd0});
  endtask

  task automatic test_underflow();
    run_and_check("dec_underflow", '{2'b00, 2'b11, 2'b00}, '{4'b0001, 4'b0001, 4'b0000},
                  '{8'h77, 8'h00, 8'h00}, '{2'd0, 2'd0, 2'd0}, '{2'd0, 2'd0, 2'd1});
  endtask

  task automatic test_no_bypass();
    run_and_check("no_bypass", '{2'b01, 2'b00}, '{4'b0010, 4'b0000},
                  '{8'h3C, 8'h00}, '{2'd1, 2'd1}, '{2'd1, 2'd2});
  endtask

  task automatic test_comb_oob();
    set_in(2'b01, 4'b0111, 8'h9E, 2'd0, 2'd0);
    cycle("oob_preload");
    o1_sel = 2'd3;
    o2_sel = 2'd2;
    #1;
    checks += 2;
    if (o1_w[3] !== 8'h00) begin errors++; $display("FAIL oob_read cfg3 o1: got %h expected 00", o1_w[3]); end
    if (o2_w[3] !== 8'(mr[3][2])) begin errors++; $display("FAIL oob_read cfg3 o2: got %h expected %h", o2_w[3], 8'(mr[3][2])); end
    run_and_check("clear_all", '{2'b00, 2'b00}, '{4'b1111, 4'b0000},
                  '{8'h00, 8'h00}, '{2'd3, 2'd1}, '{2'd2, 2'd0});
  endtask

  task automatic test_random();
    logic [7:0] d;
    for (int t = 0; t < 300; t++) begin
      case ($urandom_range(0, 3))
        0: d = 8'h00;
        1: d = 8'hFF;
        default: d = 8'($urandom);
      endcase
      set_in(2'($urandom_range(0, 3)), 4'($urandom), d, 2'($urandom), 2'($urandom));
      cycle("random");
      for (int c = 0; c < 4; c++) begin
        checks += 3;
        if (o1_w[c] !== exp_o1[c]) begin errors++; $display("FAIL random[%0d] cfg%0d o1: got %h expected %h", t, c, o1_w[c], exp_o1[c]); end
        if (o2_w[c] !== exp_o2[c]) begin errors++; $display("FAIL random[%0d] cfg%0d o2: got %h expected %h", t, c, o2_w[c], exp_o2[c]); end
        if (ovf_w[c] !== exp_ovf[c]) begin errors++; $display("FAIL random[%0d] cfg%0d ovf: got %b expected %b", t, c, ovf_w[c], exp_ovf[c]); end
      end
    end
  endtask

  initial begin
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_bypass_load();
    test_overflow();
    test_underflow();
    test_no_bypass();
    test_comb_oob();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
